// File: rtl/reg_rename_ckpt.sv
// Register rename table with a circular pool of busy/tag checkpoints for
// branch-mispredict rollback, full flush, and commit-time bypass to readers.
module reg_rename_ckpt #(
    parameter int REG_NUM  = 32,
    parameter int REG_AW   = 5,
    parameter int ENTRY_W  = 4,
    parameter int CKPT_NUM = 4,
    parameter int CKPT_W   = $clog2(CKPT_NUM)
) (
    input  logic               clk,
    input  logic               rst_n_in,
    input  logic               rdy_in,
    input  logic               issue_valid_in,
    input  logic [REG_AW-1:0]  issue_rd_in,
    input  logic [ENTRY_W-1:0] issue_entry_in,
    input  logic [REG_AW-1:0]  rs1_in,
    input  logic [REG_AW-1:0]  rs2_in,
    output logic               q1_busy_out,
    output logic               q2_busy_out,
    output logic [ENTRY_W-1:0] q1_out,
    output logic [ENTRY_W-1:0] q2_out,
    output logic [31:0]        v1_out,
    output logic [31:0]        v2_out,
    input  logic               commit_valid_in,
    input  logic [REG_AW-1:0]  commit_rd_in,
    input  logic [ENTRY_W-1:0] commit_entry_in,
    input  logic [31:0]        commit_value_in,
    input  logic               ckpt_take_in,
    output logic [CKPT_W-1:0]  ckpt_id_out,
    output logic               ckpt_full_out,
    input  logic               ckpt_release_in,
    input  logic               rollback_in,
    input  logic [CKPT_W-1:0]  rollback_id_in,
    input  logic               flush_in
);

    localparam int CNT_W = CKPT_W + 1;

    logic [31:0]        value [REG_NUM];
    logic [REG_NUM-1:0] busy;
    logic [ENTRY_W-1:0] reorder [REG_NUM];
    logic [REG_NUM-1:0] snap_busy [CKPT_NUM];
    logic [ENTRY_W-1:0] snap_reorder [CKPT_NUM][REG_NUM];
    logic [CKPT_W-1:0]  head, tail;
    logic [CNT_W-1:0]   count;

    logic               commit_eff, issue_eff, take_ok, rel_ok, rb_ok, full;
    logic [CNT_W-1:0]   rb_off;
    logic [REG_NUM-1:0] nxt_busy, rb_busy;
    logic [ENTRY_W-1:0] nxt_reorder [REG_NUM];
    logic [ENTRY_W-1:0] rb_reorder [REG_NUM];

    function automatic logic [CKPT_W-1:0] ptr_inc(input logic [CKPT_W-1:0] p);
        return (p == CKPT_W'(CKPT_NUM - 1)) ? '0 : p + CKPT_W'(1);
    endfunction

    // rdy_in low freezes every state element; read outputs keep tracking the stored table.
    always_comb begin
        full       = (count == CNT_W'(CKPT_NUM));
        commit_eff = commit_valid_in && (commit_rd_in != '0);
        if (rollback_id_in >= head)
            rb_off = CNT_W'(rollback_id_in) - CNT_W'(head);
        else
            rb_off = CNT_W'(rollback_id_in) + CNT_W'(CKPT_NUM) - CNT_W'(head);
        rb_ok     = rollback_in && (rb_off < count);
        issue_eff = issue_valid_in && (issue_rd_in != '0) && !flush_in && !rb_ok;
        take_ok   = ckpt_take_in && !flush_in && !rb_ok && (!full || ckpt_release_in);
        rel_ok    = ckpt_release_in && !flush_in && !rb_ok && (count != '0);
    end

    // Live table for the next cycle when no recovery is happening; also what a take stores.
    always_comb begin
        nxt_busy    = busy;
        nxt_reorder = reorder;
        if (commit_eff && reorder[commit_rd_in] == commit_entry_in &&
            !(issue_eff && issue_rd_in == commit_rd_in)) begin
            nxt_busy[commit_rd_in]    = 1'b0;
            nxt_reorder[commit_rd_in] = '0;
        end
        if (issue_eff) begin
            nxt_busy[issue_rd_in]    = 1'b1;
            nxt_reorder[issue_rd_in] = issue_entry_in;
        end
    end

    always_comb begin
        rb_busy    = snap_busy[rollback_id_in];
        rb_reorder = snap_reorder[rollback_id_in];
        if (commit_eff && rb_reorder[commit_rd_in] == commit_entry_in) begin
            rb_busy[commit_rd_in]    = 1'b0;
            rb_reorder[commit_rd_in] = '0;
        end
    end

    logic [REG_AW-1:0]  rs_sel [2];
    logic               rd_busy [2];
    logic [ENTRY_W-1:0] rd_q [2];
    logic [31:0]        rd_v [2];

    assign rs_sel[0] = rs1_in;
    assign rs_sel[1] = rs2_in;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_busy[p] = 1'b0;
            rd_q[p]    = '0;
            rd_v[p]    = '0;
            if (rs_sel[p] != '0) begin
                if (busy[rs_sel[p]]) begin
                    if (rdy_in && commit_eff && commit_rd_in == rs_sel[p] &&
                        commit_entry_in == reorder[rs_sel[p]]) begin
                        rd_v[p] = commit_value_in;
                    end else begin
                        rd_busy[p] = 1'b1;
                        rd_q[p]    = reorder[rs_sel[p]];
                    end
                end else begin
                    rd_v[p] = value[rs_sel[p]];
                end
            end
        end
    end

    assign q1_busy_out   = rd_busy[0];
    assign q2_busy_out   = rd_busy[1];
    assign q1_out        = rd_q[0];
    assign q2_out        = rd_q[1];
    assign v1_out        = rd_v[0];
    assign v2_out        = rd_v[1];
    assign ckpt_id_out   = tail;
    assign ckpt_full_out = full;

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int r = 0; r < REG_NUM; r++) begin
                value[r]   <= '0;
                reorder[r] <= '0;
            end
            busy <= '0;
            for (int k = 0; k < CKPT_NUM; k++) begin
                snap_busy[k] <= '0;
                for (int r = 0; r < REG_NUM; r++) snap_reorder[k][r] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (commit_eff) value[commit_rd_in] <= commit_value_in;
            // Stored snapshots retire the committing tag too; a take below overrides its own slot.
            for (int k = 0; k < CKPT_NUM; k++) begin
                if (commit_eff && snap_reorder[k][commit_rd_in] == commit_entry_in) begin
                    snap_busy[k][commit_rd_in]    <= 1'b0;
                    snap_reorder[k][commit_rd_in] <= '0;
                end
            end
            if (flush_in) begin
                busy <= '0;
                for (int r = 0; r < REG_NUM; r++) reorder[r] <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else if (rb_ok) begin
                busy    <= rb_busy;
                reorder <= rb_reorder;
                tail    <= rollback_id_in;
                count   <= rb_off;
            end else begin
                busy    <= nxt_busy;
                reorder <= nxt_reorder;
                if (take_ok) begin
                    snap_busy[tail]    <= nxt_busy;
                    snap_reorder[tail] <= nxt_reorder;
                    tail               <= ptr_inc(tail);
                end
                if (rel_ok) head <= ptr_inc(head);
                count <= count + CNT_W'(take_ok) - CNT_W'(rel_ok);
            end
        end
    end

endmodule

// File: doc/reg_rename_ckpt.md
REG_RENAME_CKPT -- requirements
Module: reg_rename_ckpt

Interface
REQ-001 SHALL have parameter REG_NUM, default 32, number of architectural registers.
REQ-002 SHALL have parameter REG_AW, default 5, register index width.
REQ-003 SHALL have parameter ENTRY_W, default 4, ROB entry tag width.
REQ-004 SHALL have parameter CKPT_NUM, default 4, checkpoint slots; CKPT_W = clog2(CKPT_NUM), default 2.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n_in  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port rdy_in  in  1  low = pause; all state held.
REQ-008 SHALL have ports issue_valid_in / issue_rd_in / issue_entry_in  in  1/REG_AW/ENTRY_W  rename rd to ROB tag.
REQ-009 SHALL have ports rs1_in, rs2_in  in  REG_AW each  source indices.
REQ-010 SHALL have ports q1_busy_out, q2_busy_out  out  1  source pending.
REQ-011 SHALL have ports q1_out, q2_out  out  ENTRY_W  producer tag, 0 when not busy.
REQ-012 SHALL have ports v1_out, v2_out  out  32  source value, 0 when busy.
REQ-013 SHALL have ports commit_valid_in / commit_rd_in / commit_entry_in / commit_value_in  in  1/REG_AW/ENTRY_W/32  ROB commit.
REQ-014 SHALL have ports ckpt_take_in  in  1; ckpt_id_out  out  CKPT_W  slot that a take this cycle uses; ckpt_full_out  out  1.
REQ-015 SHALL have port ckpt_release_in  in  1  free oldest checkpoint (branch committed).
REQ-016 SHALL have ports rollback_in / rollback_id_in  in  1/CKPT_W  mispredict recovery to slot.
REQ-017 SHALL have port flush_in  in  1  full recovery, clear all renames.

Function
REQ-018 SHALL keep per register value[32], busy, reorder[ENTRY_W]; per slot busy/reorder snapshot; head, tail, count pointers (circular, wrap at CKPT_NUM).
REQ-019 SHALL treat register 0 as never busy, value 0; issue/commit to rd 0 ignored.
REQ-020 SHALL drive read outputs combinationally from pre-edge state; same-cycle issue to rd == rs not visible.
REQ-021 SHALL bypass: rs busy, commit_valid_in, commit_entry_in == reorder[rs], commit_rd_in == rs -> busy 0, value = commit_value_in.
REQ-022 SHALL on commit write value[rd] unconditionally; clear busy/reorder only if reorder[rd] == commit_entry_in and no same-cycle issue to same rd (issue wins).
REQ-023 SHALL apply commit busy-clear rule (REQ-022 tag match) to every live snapshot too.
REQ-024 SHALL on take (count < CKPT_NUM) store next-cycle live table (incl. same-cycle issue and commit) into slot tail; tail+1, count+1.
REQ-025 SHALL assert ckpt_full_out when count == CKPT_NUM; take while full and no release ignored; take+release same cycle when full accepted, count unchanged.
REQ-026 SHALL on release (count > 0) advance head, count-1; release with count 0 ignored.
REQ-027 SHALL on rollback with live id restore busy/reorder from slot id (with same-cycle commit clear), free id and all younger: tail = id, count = id - head mod CKPT_NUM; issue, take, release ignored that cycle; value untouched.
REQ-028 SHALL ignore rollback to non-live id.
REQ-029 SHALL on flush clear all busy/reorder, head = tail = count = 0; same-cycle commit value still written; issue/take/rollback ignored.
REQ-030 SHALL prioritise reset > !rdy_in > flush > rollback > normal.

Reset
REQ-031 SHALL on rst_n_in low immediately clear all value, busy, reorder, snapshots, head, tail, count; ckpt_full_out 0, ckpt_id_out 0, q*_busy_out 0, v*_out 0.

Verification
REQ-032 SHALL cover: issue rd=5 tag 3; next cycle rs1=5 -> q1_busy 1, q1 3; commit rd5 tag3 value 0xAB same cycle -> v1 0xAB, q1_busy 0.
REQ-033 SHALL cover: issue rd=5 tag 3, then tag 7; commit tag 3 value 0x11 -> value[5] 0x11, busy stays, q1 7.
REQ-034 SHALL cover: take slot 0 clean; issue rd=6 tag 2; rollback id 0 -> rs1=6 busy 0, count 0, tail 0.
REQ-035 SHALL cover: issue rd=8 tag 1, take; commit tag 1; rollback -> rd 8 not busy (snapshot cleared).
REQ-036 SHALL cover: 4 takes -> ckpt_full_out 1, 5th take ignored; take+release -> full stays, ids wrap 3->0.
REQ-037 SHALL cover: rst_n_in pulsed low mid-cycle with busy registers -> all outputs 0 before next edge; rdy_in low holds state across issue/commit.
